cell_op_sequencer: RTL and testbench
====================================

// Module: cell_op_sequencer
// PURPOSE
//  Sequences the cell processor across a stream of pixel pairs. Accepts a command
//  (opcode, user input, pixel count), then feeds pixel pairs into the processor.
//  Captures each processedPixel after the fixed processor latency and buffers it
//  in an output FIFO. Sits between the frame fetch logic and the cell processor.
// PARAMETERS
//  PIXEL_W     8   pixel width (matches CellProcessingPkg::pixelDepth)
//  OP_W        4   opcode width (matches CellProcessingPkg::opCodeWidth)
//  CNT_W       16  command pixel-count width
//  PROC_LAT    2   cell processor latency in cycles, from input to processedPixel (>=1)
//  FIFO_DEPTH  8   output FIFO entries (power of 2, >= PROC_LAT+1)
// PORTS
//  clk             in   1        clock
//  rst             in   1        asynchronous reset, active-high
//  cmd_valid       in   1        command offered
//  cmd_ready       out  1        command accepted when cmd_valid&&cmd_ready
//  cmd_opcode      in   OP_W     opcode for the whole job
//  cmd_user        in   PIXEL_W  userInput for the whole job
//  cmd_count       in   CNT_W    pixel pairs in the job (0 = empty job)
//  in_valid        in   1        pixel pair offered
//  in_ready        out  1        pixel pair accepted when in_valid&&in_ready
//  in_pixelA       in   PIXEL_W  operand A
//  in_pixelB       in   PIXEL_W  operand B
//  proc_pixelA     out  PIXEL_W  to processor pixelA
//  proc_pixelB     out  PIXEL_W  to processor pixelB
//  proc_userInput  out  PIXEL_W  to processor userInput
//  proc_opcode     out  OP_W     to processor opcode
//  proc_result     in   PIXEL_W  from processor processedPixel
//  out_valid       out  1        result available
//  out_ready       in   1        downstream accepts result
//  out_pixel       out  PIXEL_W  result pixel
//  out_last        out  1        marks the final result of a job
//  busy            out  1        high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0 except cmd_ready=1. FIFO and counters are cleared.
//   In-flight pipeline tags are dropped.
//  FSM:
//   IDLE -cmd accepted, count>0-> RUN
//   IDLE -cmd accepted, count==0-> IDLE, with no output
//   RUN  -last pair issued-> DRAIN
//   DRAIN -last result written to FIFO-> IDLE
//  Command fields are latched on acceptance. proc_opcode/proc_userInput hold the latched
//   values until the next command. cmd_ready=1 only in IDLE.
//  Issue: in_ready = (state==RUN) && (inflight + fifo_count < FIFO_DEPTH).
//   On a handshake: proc_pixelA/B register the pair (appearing on the next cycle), and a
//   valid tag plus a last flag enter a PROC_LAT-deep shift pipe.
//  Capture: when a tag exits the pipe, proc_result is written to the FIFO with its last
//   flag. The credit rule guarantees the FIFO never overflows; no result is ever dropped.
//  Latency: in handshake at cycle N -> result enters FIFO at N+1+PROC_LAT.
//   out_valid is asserted on the following cycle when the FIFO was empty.
//  FIFO: a pop and a push in the same cycle keep the count unchanged. Write and read
//   pointers wrap modulo FIFO_DEPTH.
//  out_pixel/out_last are held stable while out_valid && !out_ready.
//  A new command may be accepted while the FIFO still drains the previous job.
//  Remaining count decrements on each issue, CNT_W wide, and never underflows.
//  Asserting rst mid-job aborts immediately. Any results already in the FIFO are lost.
// CONFIGURATION
//  CELL_SEQ_STATS_EN defined: adds output port job_done_cnt [15:0]. It increments when a
//   result with out_last pops, wraps at 0xFFFF, and resets to 0.
//  CELL_SEQ_STATS_EN undefined: the port and its counter do not exist.
// TESTING
//  1. cmd count=4, op=1, user=0x10; 4 pairs back-to-back; out_ready=1 -> 4 results in
//     order, out_last on the 4th only; busy drops at PROC_LAT+2 cycles after the last issue.
//  2. cmd count=0 -> cmd_ready stays 1, no out_valid, busy stays 0.
//  3. count=20, out_ready=0 -> in_ready drops after FIFO_DEPTH issues. No overflow.
//     Release out_ready -> all 20 results arrive in order.
//  4. out_ready toggled every cycle during a job -> out_pixel stable whenever stalled;
//     no loss or duplication.
//  5. rst asserted mid-RUN with 3 pairs in flight -> all outputs return to reset values
//     the same cycle; a following job with count=2 yields exactly 2 results.
//  6. Two jobs back-to-back (op=2 then op=3) -> proc_opcode changes only after the second
//     cmd handshake; out_last is asserted once per job.

Source files
------------

// File: rtl/cell_op_sequencer_if.sv
// Command, pixel-pair, processor and result bundle for cell_op_sequencer.
// The master side is the fetch logic plus cell processor; the slave side is the sequencer.
interface cell_op_sequencer_if #(
  parameter int PIXEL_W = 8,
  parameter int OP_W    = 4,
  parameter int CNT_W   = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [OP_W-1:0]    cmd_opcode;
  logic [PIXEL_W-1:0] cmd_user;
  logic [CNT_W-1:0]   cmd_count;
  logic               in_valid;
  logic               in_ready;
  logic [PIXEL_W-1:0] in_pixelA;
  logic [PIXEL_W-1:0] in_pixelB;
  logic [PIXEL_W-1:0] proc_pixelA;
  logic [PIXEL_W-1:0] proc_pixelB;
  logic [PIXEL_W-1:0] proc_userInput;
  logic [OP_W-1:0]    proc_opcode;
  logic [PIXEL_W-1:0] proc_result;
  logic               out_valid;
  logic               out_ready;
  logic [PIXEL_W-1:0] out_pixel;
  logic               out_last;
  logic               busy;

  modport master (
    output cmd_valid, cmd_opcode, cmd_user, cmd_count,
    output in_valid, in_pixelA, in_pixelB, proc_result, out_ready,
    input  cmd_ready, in_ready, proc_pixelA, proc_pixelB, proc_userInput, proc_opcode,
    input  out_valid, out_pixel, out_last, busy
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_user, cmd_count,
    input  in_valid, in_pixelA, in_pixelB, proc_result, out_ready,
    output cmd_ready, in_ready, proc_pixelA, proc_pixelB, proc_userInput, proc_opcode,
    output out_valid, out_pixel, out_last, busy
  );
endinterface

// File: rtl/cell_op_sequencer.sv
// Feeds pixel pairs of a command job into the cell processor and buffers its results in a FIFO.
// Optional CELL_SEQ_STATS_EN adds a completed-job counter output (job_done_cnt).
module cell_op_sequencer #(
  parameter int PIXEL_W    = 8,
  parameter int OP_W       = 4,
  parameter int CNT_W      = 16,
  parameter int PROC_LAT   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  cell_op_sequencer_if.slave  bus
`ifdef CELL_SEQ_STATS_EN
  ,
  output logic [15:0]         job_done_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                               stateR, nextStateS;
  logic [CNT_W-1:0]                     remainR;
  logic [OP_W-1:0]                      opcodeR;
  logic [PIXEL_W-1:0]                   userR, pixelAR, pixelBR;
  logic                                 issueValidR, issueLastR;
  logic [PROC_LAT-1:0]                  pipeValidR, pipeLastR;
  logic [FIFO_DEPTH-1:0][PIXEL_W-1:0]   fifoMemR;
  logic [FIFO_DEPTH-1:0]                fifoLastR;
  logic [AW-1:0]                        wrPtrR, rdPtrR;
  logic [CW-1:0]                        fifoCountR, inflightR;
  logic cmdHsS, creditS, inReadyS, inHsS, lastIssueS, captureS, popS;

  // A pair may only issue while a FIFO slot is reserved for its result.
  assign cmdHsS     = bus.cmd_valid && (stateR == IDLE);
  assign creditS    = ({1'b0, inflightR} + {1'b0, fifoCountR}) < SW'(FIFO_DEPTH);
  assign inReadyS   = (stateR == RUN) && creditS;
  assign inHsS      = bus.in_valid && inReadyS;
  assign lastIssueS = inHsS && (remainR == CNT_W'(1));
  assign captureS   = pipeValidR[PROC_LAT-1];
  assign popS       = (fifoCountR != CW'(0)) && bus.out_ready;

  assign bus.cmd_ready      = (stateR == IDLE);
  assign bus.in_ready       = inReadyS;
  assign bus.busy           = (stateR != IDLE);
  assign bus.proc_pixelA    = pixelAR;
  assign bus.proc_pixelB    = pixelBR;
  assign bus.proc_userInput = userR;
  assign bus.proc_opcode    = opcodeR;
  assign bus.out_valid      = (fifoCountR != CW'(0));
  assign bus.out_pixel      = fifoMemR[rdPtrR];
  assign bus.out_last       = fifoLastR[rdPtrR];

  // Next-state decode for the job sequencer.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: begin
        if (cmdHsS && (bus.cmd_count != CNT_W'(0))) nextStateS = RUN;
        else                                         nextStateS = IDLE;
      end
      RUN: begin
        if (lastIssueS) nextStateS = DRAIN;
        else            nextStateS = RUN;
      end
      DRAIN: begin
        if (captureS && pipeLastR[PROC_LAT-1]) nextStateS = IDLE;
        else                                   nextStateS = DRAIN;
      end
      default: nextStateS = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateR <= IDLE;
    else     stateR <= nextStateS;
  end

  // Job fields latched at command acceptance and the remaining-pair count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opcodeR <= '0;
      userR   <= '0;
      remainR <= '0;
    end else if (cmdHsS) begin
      opcodeR <= bus.cmd_opcode;
      userR   <= bus.cmd_user;
      remainR <= bus.cmd_count;
    end else if (inHsS && (remainR != CNT_W'(0))) begin
      remainR <= remainR - CNT_W'(1);
    end
  end

  // Processor operand registers and the tag pipe that tracks their results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixelAR     <= '0;
      pixelBR     <= '0;
      issueValidR <= 1'b0;
      issueLastR  <= 1'b0;
      pipeValidR  <= '0;
      pipeLastR   <= '0;
    end else begin
      if (inHsS) begin
        pixelAR <= bus.in_pixelA;
        pixelBR <= bus.in_pixelB;
      end
      issueValidR   <= inHsS;
      issueLastR    <= lastIssueS;
      pipeValidR[0] <= issueValidR;
      pipeLastR[0]  <= issueLastR;
      for (int i = 1; i < PROC_LAT; i++) begin
        pipeValidR[i] <= pipeValidR[i-1];
        pipeLastR[i]  <= pipeLastR[i-1];
      end
    end
  end

  // Result FIFO plus the count of issued pairs whose results are still in the processor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifoMemR   <= '0;
      fifoLastR  <= '0;
      wrPtrR     <= '0;
      rdPtrR     <= '0;
      fifoCountR <= '0;
      inflightR  <= '0;
    end else begin
      if (captureS) begin
        fifoMemR[wrPtrR]  <= bus.proc_result;
        fifoLastR[wrPtrR] <= pipeLastR[PROC_LAT-1];
        wrPtrR            <= wrPtrR + AW'(1);
      end
      if (popS) rdPtrR <= rdPtrR + AW'(1);
      case ({captureS, popS})
        2'b10:   fifoCountR <= fifoCountR + CW'(1);
        2'b01:   fifoCountR <= fifoCountR - CW'(1);
        default: fifoCountR <= fifoCountR;
      endcase
      case ({inHsS, captureS})
        2'b10:   inflightR <= inflightR + CW'(1);
        2'b01:   inflightR <= inflightR - CW'(1);
        default: inflightR <= inflightR;
      endcase
    end
  end

`ifdef CELL_SEQ_STATS_EN
  // Completed-job counter, advanced when a job's final result leaves the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            job_done_cnt <= 16'd0;
    else if (popS && fifoLastR[rdPtrR]) job_done_cnt <= job_done_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_cell_op_sequencer.sv
// Directed-plus-random bench for cell_op_sequencer with a latency-accurate processor stand-in
// and a queue-based reference of expected results.
module tb_cell_op_sequencer;
  localparam int PIXEL_W    = 8;
  localparam int OP_W       = 4;
  localparam int CNT_W      = 16;
  localparam int PROC_LAT   = 2;
  localparam int FIFO_DEPTH = 8;

  typedef struct packed {
    logic               last;
    logic [PIXEL_W-1:0] pix;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rxCount = 0;
  int   lastCount = 0;
  int   lastSinceRst = 0;
  int   firstOutCyc = -1;
  exp_t expQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cell_op_sequencer_if #(.PIXEL_W(PIXEL_W), .OP_W(OP_W), .CNT_W(CNT_W)) bus ();

`ifdef CELL_SEQ_STATS_EN
  logic [15:0] job_done_cnt;
`endif

  cell_op_sequencer #(
    .PIXEL_W(PIXEL_W), .OP_W(OP_W), .CNT_W(CNT_W), .PROC_LAT(PROC_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CELL_SEQ_STATS_EN
    ,
    .job_done_cnt(job_done_cnt)
`endif
  );

  function automatic logic [PIXEL_W-1:0] procFn(input logic [PIXEL_W-1:0] a, input logic [PIXEL_W-1:0] b,
                                                input logic [PIXEL_W-1:0] u, input logic [OP_W-1:0] op);
    logic [PIXEL_W-1:0] s;
    s = a + b;
    return s ^ u ^ {{(PIXEL_W-OP_W){1'b0}}, op};
  endfunction

  // Cell processor stand-in: PROC_LAT cycles from operands to processedPixel.
  logic [PIXEL_W-1:0] procPipe [PROC_LAT];
  always @(posedge clk) begin
    procPipe[0] <= procFn(bus.proc_pixelA, bus.proc_pixelB, bus.proc_userInput, bus.proc_opcode);
    for (int i = 1; i < PROC_LAT; i++) procPipe[i] <= procPipe[i-1];
  end
  assign bus.proc_result = procPipe[PROC_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every accepted pair yields one result, in order, last on the job's final pair.
  initial begin : monitor
    logic [OP_W-1:0]    mOp;
    logic [PIXEL_W-1:0] mUser, stallPix;
    logic               stallPrev, stallLast;
    int                 mRemain;
    exp_t               e;
    stallPrev = 1'b0; stallPix = '0; stallLast = 1'b0; mRemain = 0; mOp = '0; mUser = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        expQ.delete();
        stallPrev = 1'b0;
        mRemain = 0;
        lastSinceRst = 0;
      end else begin
        if (stallPrev) begin
          chk("stall_valid", 32'(bus.out_valid), 32'd1);
          chk("stall_pixel", 32'(bus.out_pixel), 32'(stallPix));
          chk("stall_last", 32'(bus.out_last), 32'(stallLast));
        end
        if (bus.out_valid && firstOutCyc < 0) firstOutCyc = cyc;
        if (bus.out_valid && bus.out_ready) begin
          total++;
          assert (expQ.size() != 0) else begin
            bad++;
            $error("FAIL spurious_out observed=out_valid expected=no_result_pending");
          end
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            chk("out_pixel", 32'(bus.out_pixel), 32'(e.pix));
            chk("out_last", 32'(bus.out_last), 32'(e.last));
          end
          rxCount++;
          if (bus.out_last) begin
            lastCount++;
            lastSinceRst++;
          end
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          mOp = bus.cmd_opcode;
          mUser = bus.cmd_user;
          mRemain = int'(bus.cmd_count);
        end
        if (bus.in_valid && bus.in_ready) begin
          mRemain--;
          e.last = (mRemain == 0);
          e.pix = procFn(bus.in_pixelA, bus.in_pixelB, mUser, mOp);
          expQ.push_back(e);
        end
        stallPrev = bus.out_valid && !bus.out_ready;
        stallPix = bus.out_pixel;
        stallLast = bus.out_last;
      end
    end
  end

  function automatic logic nextReady(input int mode);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return !bus.out_ready;
      default: return 1'($urandom_range(1));
    endcase
  endfunction

  task automatic chkReset(input string p);
    chk({p, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({p, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({p, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({p, "_busy"}, 32'(bus.busy), 32'd0);
    chk({p, "_out_pixel"}, 32'(bus.out_pixel), 32'd0);
    chk({p, "_out_last"}, 32'(bus.out_last), 32'd0);
    chk({p, "_proc_pixelA"}, 32'(bus.proc_pixelA), 32'd0);
    chk({p, "_proc_pixelB"}, 32'(bus.proc_pixelB), 32'd0);
    chk({p, "_proc_opcode"}, 32'(bus.proc_opcode), 32'd0);
    chk({p, "_proc_user"}, 32'(bus.proc_userInput), 32'd0);
  endtask

  task automatic sendCmd(input logic [OP_W-1:0] op, input logic [PIXEL_W-1:0] user, input logic [CNT_W-1:0] cnt);
    logic done;
    done = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_opcode = op; bus.cmd_user = user; bus.cmd_count = cnt;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = bus.cmd_ready;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    chk("cmd_accepted", 32'(done), 32'd1);
  endtask

  task automatic feed(input int n, input int mode, input int gapPct, output int firstHs, output int lastHs);
    int sent;
    int budget;
    sent = 0; budget = 0; firstHs = -1; lastHs = -1;
    while (sent < n && budget < 2000) begin
      bus.in_valid  = (int'($urandom_range(99)) >= gapPct);
      bus.in_pixelA = PIXEL_W'($urandom);
      bus.in_pixelB = PIXEL_W'($urandom);
      bus.out_ready = nextReady(mode);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        sent++;
        if (firstHs < 0) firstHs = cyc;
        lastHs = cyc;
      end
      @(posedge clk); #1;
      budget++;
    end
    bus.in_valid = 1'b0;
    chk("feed_done", 32'(sent), 32'(n));
  endtask

  task automatic drain(input int mode);
    int n;
    n = 0;
    while ((expQ.size() != 0 || bus.busy || bus.out_valid) && n < 1000) begin
      bus.out_ready = nextReady(mode);
      @(posedge clk); #1;
      n++;
    end
    chk("drain_in_time", 32'(n < 1000), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fh, lh, rx0, last0, hs;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_user = '0; bus.cmd_count = '0;
    bus.in_valid = 1'b0; bus.in_pixelA = '0; bus.in_pixelB = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chkReset("rst0");
    rst = 1'b0;

    // 1: four back-to-back pairs, latency and busy timing
    firstOutCyc = -1;
    rx0 = rxCount;
    sendCmd(4'd1, 8'h10, 16'd4);
    chk("t1_opcode", 32'(bus.proc_opcode), 32'd1);
    chk("t1_user", 32'(bus.proc_userInput), 32'h10);
    feed(4, 1, 0, fh, lh);
    chk("t1_back_to_back", 32'(lh - fh), 32'd3);
    for (int k = 0; k < PROC_LAT + 3; k++) begin
      @(negedge clk);
      if (cyc == lh + PROC_LAT + 1) chk("t1_busy_hold", 32'(bus.busy), 32'd1);
      if (cyc == lh + PROC_LAT + 2) chk("t1_busy_drop", 32'(bus.busy), 32'd0);
    end
    @(posedge clk); #1;
    drain(1);
    chk("t1_first_latency", 32'(firstOutCyc - fh), 32'(PROC_LAT + 2));
    chk("t1_results", 32'(rxCount - rx0), 32'd4);

    // 2: empty job
    rx0 = rxCount;
    sendCmd(4'd5, 8'h33, 16'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t2_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      chk("t2_busy", 32'(bus.busy), 32'd0);
      chk("t2_out_valid", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    chk("t2_results", 32'(rxCount - rx0), 32'd0);

    // 3: back-pressure limits issue to FIFO_DEPTH pairs
    rx0 = rxCount;
    sendCmd(4'd7, 8'hA5, 16'd20);
    hs = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      bus.in_valid = 1'b1;
      bus.in_pixelA = PIXEL_W'($urandom);
      bus.in_pixelB = PIXEL_W'($urandom);
      @(negedge clk);
      if (bus.in_ready) hs++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("t3_credit_issues", 32'(hs), 32'(FIFO_DEPTH));
    chk("t3_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("t3_out_valid", 32'(bus.out_valid), 32'd1);
    feed(20 - FIFO_DEPTH, 1, 0, fh, lh);
    drain(1);
    chk("t3_results", 32'(rxCount - rx0), 32'd20);

    // 4: out_ready toggling every cycle
    rx0 = rxCount;
    sendCmd(4'd9, 8'h5A, 16'd12);
    feed(12, 2, 25, fh, lh);
    drain(2);
    chk("t4_results", 32'(rxCount - rx0), 32'd12);

    // 5: reset mid-RUN with three pairs in flight
    sendCmd(4'd4, 8'hC3, 16'd10);
    feed(3, 0, 0, fh, lh);
    rst = 1'b1;
    #1;
    chkReset("rst_mid");
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    rx0 = rxCount;
    sendCmd(4'd6, 8'h0F, 16'd2);
    feed(2, 1, 0, fh, lh);
    drain(1);
    chk("t5_results", 32'(rxCount - rx0), 32'd2);

    // 6: two jobs back-to-back
    rx0 = rxCount;
    last0 = lastCount;
    sendCmd(4'd2, 8'h21, 16'd3);
    feed(3, 1, 0, fh, lh);
    chk("t6_opcode_hold", 32'(bus.proc_opcode), 32'd2);
    sendCmd(4'd3, 8'h42, 16'd3);
    chk("t6_opcode_new", 32'(bus.proc_opcode), 32'd3);
    feed(3, 1, 0, fh, lh);
    drain(1);
    chk("t6_results", 32'(rxCount - rx0), 32'd6);
    chk("t6_last_per_job", 32'(lastCount - last0), 32'd2);

    // random jobs with random gaps and back-pressure
    for (int j = 0; j < 5; j++) begin
      int cnt;
      cnt = int'($urandom_range(1, 14));
      rx0 = rxCount;
      sendCmd(OP_W'($urandom), PIXEL_W'($urandom), CNT_W'(cnt));
      feed(cnt, 3, 30, fh, lh);
      drain(3);
      chk("rand_results", 32'(rxCount - rx0), 32'(cnt));
    end

`ifdef CELL_SEQ_STATS_EN
    chk("job_done_cnt", 32'(job_done_cnt), 32'(lastSinceRst));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
